mem_access_unit: RTL and testbench

MEM-stage load/store unit between the EX/MEM pipeline register and the MEM/WB register. It turns a load/store from EX/MEM into a request/acknowledge transaction on the data-memory bus, with byte-lane alignment and store byte-enables. Load data is sign- or zero-extended and registered so the MEM/WB register can capture it. The pipeline is stalled while a transaction is outstanding, and misaligned/illegal accesses and bus timeouts are flagged.

---
 rtl/mem_access_unit.sv | 162 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns an EX/MEM load/store into a req/ack data-memory
// transaction, aligns store lanes, extends load data and stalls the pipeline meanwhile.
module mem_access_unit #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mem_valid,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [2:0]  ex_mem_funct3,
  input  logic [31:0] ex_mem_alu_result,
  input  logic [31:0] ex_mem_store_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] mem_read_data,
  output logic        mem_done,
  output logic        mem_stall,
  output logic        misaligned,
  output logic        bus_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       funct3_p0;
  logic [1:0]       lane_p0;

  logic is_store, access, legal, aligned, start, bad, timeout_hit;

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
    case (f3[1:0])
      2'b00:   store_be = 4'b0001 << lane;
      2'b01:   store_be = lane[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] data);
    case (f3[1:0])
      2'b00:   store_wdata = {4{data[7:0]}};
      2'b01:   store_wdata = {2{data[15:0]}};
      default: store_wdata = data;
    endcase
  endfunction

  function automatic logic [31:0] format_load(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] rdata);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] sx;
    case (lane)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    sx = 32'sd0;
    case (f3)
      3'b000:  begin sx = b; format_load = sx; end
      3'b001:  begin sx = h; format_load = sx; end
      3'b100:  format_load = {24'd0, b};
      3'b101:  format_load = {16'd0, h};
      default: format_load = rdata;
    endcase
  endfunction

  // A simultaneous read+write request is handled as a store.
  always_comb begin
    is_store = MemWrite_in;
    access   = ex_mem_valid & (MemRead_in | MemWrite_in);
    if (is_store)
      legal = (ex_mem_funct3 == 3'b000) | (ex_mem_funct3 == 3'b001) | (ex_mem_funct3 == 3'b010);
    else
      legal = (ex_mem_funct3 == 3'b000) | (ex_mem_funct3 == 3'b001) | (ex_mem_funct3 == 3'b010) |
              (ex_mem_funct3 == 3'b100) | (ex_mem_funct3 == 3'b101);
    case (ex_mem_funct3[1:0])
      2'b01:   aligned = ~ex_mem_alu_result[0];
      2'b10:   aligned = (ex_mem_alu_result[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    start       = (state == IDLE) & access & legal & aligned;
    bad         = (state == IDLE) & access & ~(legal & aligned);
    timeout_hit = (cnt == CNT_W'(TIMEOUT_CYC - 1));
    mem_stall   = ~rst & (start | (state == REQ));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      funct3_p0     <= 3'd0;
      lane_p0       <= 2'd0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= 32'd0;
      dmem_wdata    <= 32'd0;
      dmem_be       <= 4'd0;
      mem_read_data <= 32'd0;
      mem_done      <= 1'b0;
      misaligned    <= 1'b0;
      bus_timeout   <= 1'b0;
    end else begin
      mem_done    <= 1'b0;
      misaligned  <= 1'b0;
      bus_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= REQ;
            cnt        <= '0;
            dmem_req   <= 1'b1;
            dmem_we    <= is_store;
            dmem_addr  <= {ex_mem_alu_result[31:2], 2'b00};
            dmem_be    <= store_be(ex_mem_funct3, ex_mem_alu_result[1:0]);
            dmem_wdata <= store_wdata(ex_mem_funct3, ex_mem_store_data);
            funct3_p0  <= ex_mem_funct3;
            lane_p0    <= ex_mem_alu_result[1:0];
          end else if (bad) begin
            misaligned    <= 1'b1;
            mem_read_data <= 32'd0;
          end
        end
        // REQ: bus signals held; count cycles until ack or abort
        REQ: begin
          if (dmem_ack) begin
            state    <= RESP;
            dmem_req <= 1'b0;
            mem_done <= 1'b1;
            cnt      <= '0;
            if (!dmem_we)
              mem_read_data <= format_load(funct3_p0, lane_p0, dmem_rdata);
          end else if (timeout_hit) begin
            state         <= RESP;
            dmem_req      <= 1'b0;
            mem_done      <= 1'b1;
            bus_timeout   <= 1'b1;
            mem_read_data <= 32'd0;
            cnt           <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // RESP: pipeline advances this cycle, never re-evaluate start here
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: bus responder, scoreboard queues and a monitor
// that checks each bus request and each completion/misaligned/timeout pulse.
module tb_mem_access_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_mem_valid, MemRead_in, MemWrite_in;
  logic [2:0]  ex_mem_funct3;
  logic [31:0] ex_mem_alu_result, ex_mem_store_data;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] mem_read_data;
  logic        mem_done, mem_stall, misaligned, bus_timeout;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .ex_mem_valid(ex_mem_valid), .MemRead_in(MemRead_in),
    .MemWrite_in(MemWrite_in), .ex_mem_funct3(ex_mem_funct3),
    .ex_mem_alu_result(ex_mem_alu_result), .ex_mem_store_data(ex_mem_store_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .mem_read_data(mem_read_data), .mem_done(mem_done), .mem_stall(mem_stall),
    .misaligned(misaligned), .bus_timeout(bus_timeout)
  );

  typedef struct { logic misal; logic tmo; logic [31:0] rd; int stalls; } resp_t;
  typedef struct { logic [31:0] addr; logic we; logic chk_data; logic [3:0] be; logic [31:0] wdata; } bus_t;

  resp_t resp_q[$];
  bus_t  bus_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int ack_after = 1;
  logic [31:0] rd_val = 32'd0;
  logic stray_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_bus(input logic [31:0] a, input logic we, input logic cd,
                         input logic [3:0] be, input logic [31:0] wd);
    bus_t b;
    b.addr = a; b.we = we; b.chk_data = cd; b.be = be; b.wdata = wd;
    bus_q.push_back(b);
  endtask

  task automatic exp_resp(input logic m, input logic t, input logic [31:0] rd, input int st);
    resp_t r;
    r.misal = m; r.tmo = t; r.rd = rd; r.stalls = st;
    resp_q.push_back(r);
  endtask

  // Memory responder: ack on the ack_after-th REQ cycle (0 = never)
  initial begin
    int rc;
    rc = 0;
    dmem_ack = 1'b0;
    dmem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rc = 0;
        dmem_ack = 1'b0;
      end else if (dmem_req) begin
        rc++;
        dmem_ack = (ack_after != 0) && (rc == ack_after);
        dmem_rdata = dmem_ack ? rd_val : 32'h0BAD0BAD;
      end else begin
        rc = 0;
        dmem_ack = stray_ack;
        dmem_rdata = stray_ack ? 32'hFFFFFFFF : 32'd0;
      end
    end
  end

  // Monitor: checks each new bus request and each completion-type pulse
  initial begin
    logic prev_req;
    int stalls;
    bus_t b;
    resp_t r;
    prev_req = 1'b0;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_req = 1'b0;
        stalls = 0;
      end else begin
        if (mem_stall) stalls++;
        if (dmem_req && !prev_req) begin
          if (bus_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_req: got addr %h expected no request", dmem_addr);
          end else begin
            b = bus_q.pop_front();
            check("dmem_addr", dmem_addr, b.addr);
            check("dmem_we", 32'(dmem_we), 32'(b.we));
            if (b.chk_data) begin
              check("dmem_be", 32'(dmem_be), 32'(b.be));
              check("dmem_wdata", dmem_wdata, b.wdata);
            end
          end
        end
        if (mem_done || misaligned || bus_timeout) begin
          if (resp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_resp: got done=%b mis=%b tmo=%b expected none",
                     mem_done, misaligned, bus_timeout);
          end else begin
            r = resp_q.pop_front();
            check("mem_done", 32'(mem_done), 32'(!r.misal));
            check("misaligned", 32'(misaligned), 32'(r.misal));
            check("bus_timeout", 32'(bus_timeout), 32'(r.tmo));
            check("mem_read_data", mem_read_data, r.rd);
            check("stall_cycles", 32'(stalls), 32'(r.stalls));
          end
          stalls = 0;
        end
        prev_req = dmem_req;
      end
    end
  end

  task automatic do_acc(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data,
                        input int ack_n, input logic [31:0] rdata, input bit good);
    int k;
    ack_after = ack_n;
    rd_val = rdata;
    @(posedge clk); #1;
    ex_mem_valid = 1'b1; MemRead_in = rd; MemWrite_in = wr;
    ex_mem_funct3 = f3; ex_mem_alu_result = addr; ex_mem_store_data = data;
    if (good) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!mem_done && k < 50);
      if (!mem_done) begin
        n_checks++; n_fail++;
        $display("FAIL wait_done: got no mem_done expected within 50 cycles");
      end
    end
    @(posedge clk); #1;
    ex_mem_valid = 1'b0; MemRead_in = 1'b0; MemWrite_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    ex_mem_valid = 1'b1; MemRead_in = 1'b1; MemWrite_in = 1'b0;
    ex_mem_funct3 = 3'b010; ex_mem_alu_result = 32'd0; ex_mem_store_data = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", 32'(mem_stall), 32'd0);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_be", 32'(dmem_be), 32'd0);
    check("rst_rdata", mem_read_data, 32'd0);
    check("rst_done", 32'(mem_done), 32'd0);
    ex_mem_valid = 1'b0; MemRead_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Stores
    exp_bus(32'h104, 1'b1, 1'b1, 4'b1111, 32'hDEADBEEF); exp_resp(0, 0, 32'h0, 2);
    do_acc(0, 1, 3'b010, 32'h104, 32'hDEADBEEF, 1, 32'h0, 1);
    exp_bus(32'h200, 1'b1, 1'b1, 4'b1000, 32'hA5A5A5A5); exp_resp(0, 0, 32'h0, 2);
    do_acc(0, 1, 3'b000, 32'h203, 32'h000000A5, 1, 32'h0, 1);

    // Loads and extension
    exp_bus(32'h100, 1'b0, 1'b0, 4'b0, 32'h0); exp_resp(0, 0, 32'hFFFFFF80, 4);
    do_acc(1, 0, 3'b000, 32'h102, 32'h0, 3, 32'h12807F34, 1);
    exp_bus(32'h100, 1'b0, 1'b0, 4'b0, 32'h0); exp_resp(0, 0, 32'h00000080, 4);
    do_acc(1, 0, 3'b100, 32'h102, 32'h0, 3, 32'h12807F34, 1);
    exp_bus(32'h100, 1'b0, 1'b0, 4'b0, 32'h0); exp_resp(0, 0, 32'h00001280, 2);
    do_acc(1, 0, 3'b001, 32'h102, 32'h0, 1, 32'h12807F34, 1);
    exp_bus(32'h100, 1'b0, 1'b0, 4'b0, 32'h0); exp_resp(0, 0, 32'h0000007F, 2);
    do_acc(1, 0, 3'b000, 32'h101, 32'h0, 1, 32'h12807F34, 1);
    exp_bus(32'h100, 1'b0, 1'b0, 4'b0, 32'h0); exp_resp(0, 0, 32'hFFFF8001, 2);
    do_acc(1, 0, 3'b001, 32'h100, 32'h0, 1, 32'h00008001, 1);
    exp_bus(32'h100, 1'b0, 1'b0, 4'b0, 32'h0); exp_resp(0, 0, 32'h00008001, 2);
    do_acc(1, 0, 3'b101, 32'h100, 32'h0, 1, 32'h00008001, 1);
    exp_bus(32'h108, 1'b0, 1'b0, 4'b0, 32'h0); exp_resp(0, 0, 32'hCAFEF00D, 3);
    do_acc(1, 0, 3'b010, 32'h108, 32'h0, 2, 32'hCAFEF00D, 1);

    // Read+write together behaves as a store and leaves load data alone
    exp_bus(32'h204, 1'b1, 1'b1, 4'b1100, 32'hBEEFBEEF); exp_resp(0, 0, 32'hCAFEF00D, 2);
    do_acc(1, 1, 3'b001, 32'h206, 32'h1234BEEF, 1, 32'h0, 1);

    // Misaligned / illegal
    exp_resp(1, 0, 32'h0, 0);
    do_acc(1, 0, 3'b010, 32'h101, 32'h0, 1, 32'h0, 0);
    exp_resp(1, 0, 32'h0, 0);
    do_acc(1, 0, 3'b011, 32'h100, 32'h0, 1, 32'h0, 0);
    exp_resp(1, 0, 32'h0, 0);
    do_acc(0, 1, 3'b100, 32'h100, 32'h0, 1, 32'h0, 0);
    exp_resp(1, 0, 32'h0, 0);
    do_acc(1, 0, 3'b001, 32'h103, 32'h0, 1, 32'h0, 0);

    // Timeout after TO REQ cycles
    exp_bus(32'h10C, 1'b0, 1'b0, 4'b0, 32'h0); exp_resp(0, 1, 32'h0, TO + 1);
    do_acc(1, 0, 3'b010, 32'h10C, 32'h0, 0, 32'h0, 1);

    // Reset during REQ
    ack_after = 0;
    exp_bus(32'h300, 1'b0, 1'b0, 4'b0, 32'h0);
    @(posedge clk); #1;
    ex_mem_valid = 1'b1; MemRead_in = 1'b1; ex_mem_funct3 = 3'b010; ex_mem_alu_result = 32'h300;
    repeat (2) @(posedge clk);
    #1;
    check("req_before_rst", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    #1;
    check("req_async_rst", 32'(dmem_req), 32'd0);
    check("stall_async_rst", 32'(mem_stall), 32'd0);
    ex_mem_valid = 1'b0; MemRead_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Stray ack while idle must be ignored
    @(posedge clk); #1;
    stray_ack = 1'b1;
    @(posedge clk); #1;
    stray_ack = 1'b0;
    @(negedge clk);
    check("stray_req", 32'(dmem_req), 32'd0);
    check("stray_rdata", mem_read_data, 32'd0);

    exp_bus(32'h0, 1'b0, 1'b0, 4'b0, 32'h0); exp_resp(0, 0, 32'h11223344, 2);
    do_acc(1, 0, 3'b010, 32'h0, 32'h0, 1, 32'h11223344, 1);

    repeat (5) @(posedge clk);
    #1;
    check("resp_q_empty", 32'(resp_q.size()), 32'd0);
    check("bus_q_empty", 32'(bus_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
